// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types for the reorder buffer
package rob_pkg;

  localparam int ROB_W_DEFAULT = 3;

  typedef logic [ROB_W_DEFAULT-1:0] rob_tag_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        mispredict;
    logic [31:0] next_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order commit buffer feeding the register file write port
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_W = ROB_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic             issue_has_rd,
  input  logic [4:0]       issue_rd,
  input  logic             issue_ready,
  input  logic [31:0]      issue_value,
  output logic [ROB_W-1:0] issue_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_next_pc,
  input  logic [ROB_W-1:0] query_tag,
  output logic             query_ready,
  output logic [31:0]      query_value,
  output logic             rf_have_task,
  output logic [4:0]       rf_reg_id,
  output logic             rf_rw,
  output logic [31:0]      rf_data,
  output logic             flush_out,
  output logic [31:0]      flush_pc
);

  localparam int DEPTH = 1 << ROB_W;
  localparam logic [ROB_W:0]   COUNT_FULL = (ROB_W+1)'(DEPTH);
  localparam logic [ROB_W:0]   COUNT_ONE  = (ROB_W+1)'(1);
  localparam logic [ROB_W-1:0] TAG_ONE    = ROB_W'(1);

  rob_entry_t       rob [DEPTH];
  logic [ROB_W-1:0] head;
  logic [ROB_W-1:0] tail;
  logic [ROB_W:0]   count;

  rob_entry_t head_e;
  logic       commit_fire;
  logic       commit_write;
  logic       flush_take;
  logic       issue_fire;
  logic       cdb_fire;

  always_comb begin
    head_e       = rob[head];
    commit_fire  = rdy_in && head_e.busy && head_e.ready;
    flush_take   = commit_fire && head_e.mispredict;
    commit_write = commit_fire && !head_e.mispredict && head_e.has_rd && (head_e.rd != 5'd0);
    issue_fire   = issue_valid && !full && rdy_in && !flush_take;
    cdb_fire     = cdb_valid && rdy_in && rob[cdb_tag].busy;
  end

  assign full        = (count == COUNT_FULL);
  assign issue_tag   = tail;
  assign query_ready = rob[query_tag].busy && rob[query_tag].ready;
  assign query_value = rob[query_tag].value;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      rf_have_task <= 1'b0;
      rf_reg_id    <= '0;
      rf_rw        <= 1'b0;
      rf_data      <= '0;
      flush_out    <= 1'b0;
      flush_pc     <= '0;
    end else begin
      rf_have_task <= 1'b0;
      rf_rw        <= 1'b0;
      flush_out    <= 1'b0;
      if (flush_take) begin
        // Mispredicted branch at head: drop everything younger, including this edge's issue/CDB.
        for (int i = 0; i < DEPTH; i++) rob[i].busy <= 1'b0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        flush_out <= 1'b1;
        flush_pc  <= head_e.next_pc;
      end else begin
        if (cdb_fire) begin
          rob[cdb_tag].ready      <= 1'b1;
          rob[cdb_tag].value      <= cdb_value;
          rob[cdb_tag].mispredict <= cdb_mispredict;
          rob[cdb_tag].next_pc    <= cdb_next_pc;
        end
        if (issue_fire) begin
          rob[tail] <= '{busy: 1'b1, ready: issue_ready, has_rd: issue_has_rd, rd: issue_rd,
                         value: issue_value, mispredict: 1'b0, next_pc: 32'd0};
          tail <= tail + TAG_ONE;
        end
        if (commit_fire) begin
          rob[head].busy <= 1'b0;
          head           <= head + TAG_ONE;
          if (commit_write) begin
            rf_have_task <= 1'b1;
            rf_rw        <= 1'b1;
            rf_reg_id    <= head_e.rd;
            rf_data      <= head_e.value;
          end
        end
        case ({issue_fire, commit_fire})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer between out-of-order execution and register_file (directly upstream of its write port).
- Issue allocates a tagged entry; execution results arrive on the CDB; the oldest completed entry retires one per cycle into register_file via have_task/reg_id/rw/data_in.
- A mispredicted branch at the head flushes the buffer and signals a PC redirect.

Parameters:
- ROB_W, 3, log2 of entry count (2**ROB_W entries, default 8)

Ports:
- clk_in  input  1  system clock, single clock domain
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  when low, freeze all state; outputs hold except rf_have_task=0
- issue_valid  input  1  allocate entry this cycle
- issue_has_rd  input  1  instruction writes a destination register
- issue_rd  input  5  destination register id
- issue_ready  input  1  result already known at issue
- issue_value  input  32  result when issue_ready=1
- issue_tag  output  ROB_W  tag of the entry the next issue receives (current tail)
- full  output  1  no free entry
- cdb_valid  input  1  result broadcast
- cdb_tag  input  ROB_W  entry being completed
- cdb_value  input  32  result value
- cdb_mispredict  input  1  completed entry is a mispredicted branch
- cdb_next_pc  input  32  correct PC for a mispredict
- query_tag  input  ROB_W  operand lookup tag
- query_ready  output  1  combinational: entry busy and ready
- query_value  output  32  combinational: entry value
- rf_have_task  output  1  commit request to register_file
- rf_reg_id  output  5  commit destination
- rf_rw  output  1  1 = write; always 1 when rf_have_task=1
- rf_data  output  32  commit value
- flush_out  output  1  one-cycle flush pulse
- flush_pc  output  32  redirect PC, valid with flush_out

Behaviour:
- Reset (async, rst_in=1):
  - head=tail=0, count=0, all busy/ready bits cleared.
  - All registered outputs 0: rf_*, flush_out, flush_pc.
- State:
  - Per entry: busy, ready, has_rd, rd, value, mispredict, next_pc.
  - count is ROB_W+1 bits. full = (count == 2**ROB_W).
  - Pointers wrap modulo 2**ROB_W.
- Issue:
  - Accepted on an edge when issue_valid && !full && rdy_in && no flush is being taken that edge.
  - Writes the entry at tail; tail++, count++.
  - issue_valid while full is ignored; the upstream stage must hold. No bypass when a commit occurs in the same cycle.
- CDB:
  - On an edge with cdb_valid && busy[cdb_tag], set ready and store value/mispredict/next_pc.
  - cdb_valid to a non-busy tag is ignored.
  - A CDB write and an issue to the same index in one cycle cannot occur, because a busy entry is never the tail.
- Commit (evaluated on registered state):
  - If busy[head] && ready[head] && rdy_in, retire head: head++, count--.
  - If !mispredict and has_rd and rd != 0: next cycle rf_have_task=1, rf_rw=1, rf_reg_id=rd, rf_data=value.
  - Otherwise rf_have_task=0.
  - rf_have_task is otherwise 0 every cycle; it is a single-cycle pulse per commit.
- Latency:
  - An entry made ready at edge N retires at edge N+1.
  - rf_have_task is visible in the cycle after edge N+1.
  - A CDB write for the head at edge N also retires at N+1.
- Flush (head retires with mispredict=1):
  - flush_out=1 and flush_pc=next_pc for exactly one cycle.
  - All busy bits cleared; head=tail=0, count=0.
  - Simultaneous issue and CDB writes that edge are discarded.
  - The branch itself produces no register write.
- Simultaneous issue + commit: both apply; count unchanged.
- Query: combinational read of entry[query_tag]; query_ready=0 if the entry is not busy.
- rdy_in low: no issue, CDB, or commit state changes; rf_have_task=0, flush_out=0.
- Reset mid-operation: asynchronously returns to the reset state; in-flight entries are lost.

Decomposition:
- Shared package rob_pkg:
  - ROB_W default.
  - rob_entry_t struct {busy, ready, has_rd, rd[4:0], value[31:0], mispredict, next_pc[31:0]}.
  - Tag type rob_tag_t.
- No sub-module needed; entry storage is a flat register array inside reorder_buffer.

Test Plan:
- Issue rd=5 with issue_ready=1, value=0xDEADBEEF into an empty buffer:
  - tag 0 assigned.
  - Two cycles later rf_have_task=1, rf_reg_id=5, rf_data=0xDEADBEEF, for one cycle only.
- Out-of-order completion:
  - Issue tags 0,1,2 (rd=1,2,3) not ready.
  - CDB tag2=0x33, then tag0=0x11, then tag1=0x22.
  - Commits occur in order rd1, rd2, rd3 with values 0x11, 0x22, 0x33.
- Full/wrap:
  - Issue 8 entries, then assert issue_valid once more: full=1 and the 9th is ignored.
  - Complete and commit all 8, then issue again: issue_tag wraps from 7 to 0.
- Mispredict:
  - Issue branch (tag0) plus 3 more.
  - CDB tag0 with mispredict=1, next_pc=0x1000.
  - flush_out=1 with flush_pc=0x1000 for one cycle; no rf write.
  - full=0, issue_tag=0, and the later entries never commit.
- rd=x0 and rdy_in stall:
  - A ready entry with rd=0 commits with rf_have_task=0.
  - rdy_in=0 for 3 cycles with a ready head: no commit and count unchanged; the commit resumes the edge after rdy_in=1.
- Async reset:
  - Assert rst_in mid-cycle with 4 busy entries.
  - full=0, issue_tag=0, and all outputs 0 before the next clock edge.
